// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS tuning word from a start value to a stop
// value in fixed increments, holding each word for dwell+1 cycles.
// Supports single-shot, repeating sawtooth and triangle (bounce) sweeps
// with a start/busy/done handshake. All outputs come straight from flops.
module dds_sweep_ctrl #(
  parameter int FW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] start_freq,
  input  logic [FW-1:0] stop_freq,
  input  logic [FW-1:0] step,
  input  logic [DW-1:0] dwell,
  input  logic [1:0]    mode,
  output logic [FW-1:0] freq_ctrl,
  output logic          freq_upd,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] cnt_reg, cnt_next;
  logic [FW-1:0] freq_reg, freq_next;
  logic [FW-1:0] target_reg, target_next;
  logic          dir_up_reg, dir_up_next;
  logic          upd_reg, upd_next;
  logic          done_reg, done_next;

  // Configuration captured on an accepted start; inputs are free to move afterwards.
  logic [FW-1:0] cfg_start_reg, cfg_start_next;
  logic [FW-1:0] cfg_stop_reg, cfg_stop_next;
  logic [FW-1:0] cfg_step_reg, cfg_step_next;
  logic [DW-1:0] cfg_dwell_reg, cfg_dwell_next;
  logic [1:0]    cfg_mode_reg, cfg_mode_next;

  // Scratch values for the triangle turnaround.
  logic          tri_up;
  logic [FW-1:0] tri_target;

  // One step toward tgt, computed one bit wider so overflow (up) and borrow
  // (down) are visible; any overshoot clamps onto the target.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                input logic          up,
                                                input logic [FW-1:0] tgt,
                                                input logic [FW-1:0] inc);
    logic [FW:0]   wide;
    logic [FW-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, inc};
      res  = (wide > {1'b0, tgt}) ? tgt : wide[FW-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, inc};
      res  = (wide[FW] || (wide[FW-1:0] < tgt)) ? tgt : wide[FW-1:0];
    end
    return res;
  endfunction

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      freq_reg      <= '0;
      target_reg    <= '0;
      dir_up_reg    <= 1'b0;
      upd_reg       <= 1'b0;
      done_reg      <= 1'b0;
      cfg_start_reg <= '0;
      cfg_stop_reg  <= '0;
      cfg_step_reg  <= '0;
      cfg_dwell_reg <= '0;
      cfg_mode_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      freq_reg      <= freq_next;
      target_reg    <= target_next;
      dir_up_reg    <= dir_up_next;
      upd_reg       <= upd_next;
      done_reg      <= done_next;
      cfg_start_reg <= cfg_start_next;
      cfg_stop_reg  <= cfg_stop_next;
      cfg_step_reg  <= cfg_step_next;
      cfg_dwell_reg <= cfg_dwell_next;
      cfg_mode_reg  <= cfg_mode_next;
    end
  end

  // Next-state logic: start acceptance, dwell countdown, stepping and end-of-sweep handling.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    freq_next      = freq_reg;
    target_next    = target_reg;
    dir_up_next    = dir_up_reg;
    upd_next       = 1'b0;
    done_next      = 1'b0;
    cfg_start_next = cfg_start_reg;
    cfg_stop_next  = cfg_stop_reg;
    cfg_step_next  = cfg_step_reg;
    cfg_dwell_next = cfg_dwell_reg;
    cfg_mode_next  = cfg_mode_reg;
    tri_up         = dir_up_reg;
    tri_target     = target_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          cfg_start_next = start_freq;
          cfg_stop_next  = stop_freq;
          // A zero increment would never reach the target, so it behaves as 1.
          cfg_step_next  = (step == '0) ? FW'(1) : step;
          cfg_dwell_next = dwell;
          cfg_mode_next  = mode;
          dir_up_next    = (stop_freq >= start_freq);
          target_next    = stop_freq;
          freq_next      = start_freq;
          upd_next       = 1'b1;
          cnt_next       = dwell;
          state_next     = DWELL;
        end
      end

      DWELL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DW'(1);
        end else if (freq_reg != target_reg) begin
          freq_next = step_toward(freq_reg, dir_up_reg, target_reg, cfg_step_reg);
          upd_next  = 1'b1;
          cnt_next  = cfg_dwell_reg;
        end else begin
          case (cfg_mode_reg)
            2'b01: begin
              // Sawtooth: jump back to the start word; no pulse if it is already there.
              freq_next = cfg_start_reg;
              upd_next  = (cfg_start_reg != freq_reg);
              cnt_next  = cfg_dwell_reg;
            end
            2'b10: begin
              // Triangle: turn around and take the first step immediately so the
              // endpoint is not held for two dwell periods.
              tri_up      = ~dir_up_reg;
              tri_target  = (target_reg == cfg_stop_reg) ? cfg_start_reg : cfg_stop_reg;
              dir_up_next = tri_up;
              target_next = tri_target;
              freq_next   = step_toward(freq_reg, tri_up, tri_target, cfg_step_reg);
              upd_next    = (freq_next != freq_reg);
              cnt_next    = cfg_dwell_reg;
            end
            default: begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          endcase
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign freq_ctrl = freq_reg;
  assign freq_upd  = upd_reg;
  assign done      = done_reg;
  assign busy      = (state_reg == DWELL);

endmodule
